// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator controller: FSM state doubles as the cur_cmd code.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    SERVE     = 2'b11
  } state_t;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_UP    = 2'b01;
  localparam logic [1:0] CMD_DOWN  = 2'b10;
  localparam logic [1:0] CMD_SERVE = 2'b11;

endpackage

// File: rtl/elevator_req_scan.sv
// Request lookahead: reports whether any pending request lies above, below or at a given floor.
module elevator_req_scan #(
  parameter int N_FLOORS = 8,
  parameter int F_BITS   = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] req,
  input  logic [F_BITS-1:0]   floor,
  output logic                any_above,
  output logic                any_below,
  output logic                at_floor
);

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    at_floor  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(floor))      any_above = any_above | req[i];
      else if (i < int'(floor)) any_below = any_below | req[i];
      else                      at_floor  = req[i];
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: request latches, travel/door timers and the IDLE/MOVE/SERVE FSM.
// Optional door-hold support is compiled in with ELEVATOR_DOOR_HOLD_EN.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS      = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_FLOORS-1:0]         ext_up,
  input  logic [N_FLOORS-1:0]         ext_down,
  input  logic [N_FLOORS-1:0]         ext_floor,
  input  logic                        door_hold,
  output logic [$clog2(N_FLOORS)-1:0] cur_floor,
  output logic [1:0]                  cur_cmd,
  output logic                        doors_open,
  output logic [N_FLOORS-1:0]         u_buttons,
  output logic [N_FLOORS-1:0]         d_buttons,
  output logic [N_FLOORS-1:0]         f_buttons,
  output logic                        dir_up
);

  localparam int F_BITS = $clog2(N_FLOORS);
  localparam int TW     = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW     = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  state_t              state, state_n;
  logic [F_BITS-1:0]   floor_n, scan_floor;
  logic                dir_n;
  logic [TW-1:0]       travel_cnt, travel_n;
  logic [DW-1:0]       door_cnt, door_n;
  logic [N_FLOORS-1:0] up_in, dn_in, sel, clr_u, clr_d, clr_f;
  logic                arrive, any_above, any_below, at_floor;
  logic                hold_act, new_here, clr_here, clr_opp;

  assign up_in  = ext_up & UP_MASK;
  assign dn_in  = ext_down & DN_MASK;
  assign arrive = (travel_cnt == TW'(TRAVEL_CYCLES - 1));

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign hold_act = door_hold;
`else
  logic unused_door_hold;
  assign unused_door_hold = door_hold;
  assign hold_act         = 1'b0;
`endif

  // On an arrival edge the lookahead looks at the floor being reached, otherwise at the car.
  always_comb begin
    scan_floor = cur_floor;
    if (arrive && state == MOVE_UP && cur_floor != F_BITS'(N_FLOORS - 1))
      scan_floor = cur_floor + 1'b1;
    else if (arrive && state == MOVE_DOWN && cur_floor != '0)
      scan_floor = cur_floor - 1'b1;
  end

  elevator_req_scan #(.N_FLOORS(N_FLOORS), .F_BITS(F_BITS)) u_scan (
    .req       (u_buttons | d_buttons | f_buttons),
    .floor     (scan_floor),
    .any_above (any_above),
    .any_below (any_below),
    .at_floor  (at_floor)
  );

  assign new_here = ext_floor[cur_floor] | (dir_up ? up_in[cur_floor] : dn_in[cur_floor]);

  always_comb begin
    state_n  = state;
    floor_n  = cur_floor;
    dir_n    = dir_up;
    travel_n = travel_cnt;
    door_n   = door_cnt;
    clr_here = 1'b0;
    clr_opp  = 1'b0;
    case (state)
      IDLE: begin
        travel_n = '0;
        door_n   = '0;
        if (at_floor) begin
          state_n  = SERVE;
          clr_here = 1'b1;
          clr_opp  = dir_up ? !any_above : !any_below;
        end else if (any_above) begin
          state_n = MOVE_UP;
          dir_n   = 1'b1;
        end else if (any_below) begin
          state_n = MOVE_DOWN;
          dir_n   = 1'b0;
        end
      end
      MOVE_UP: begin
        if (arrive) begin
          travel_n = '0;
          floor_n  = scan_floor;
          if (f_buttons[scan_floor] || u_buttons[scan_floor] || !any_above) begin
            state_n  = SERVE;
            door_n   = '0;
            clr_here = 1'b1;
            clr_opp  = !any_above;
          end
        end else begin
          travel_n = travel_cnt + 1'b1;
        end
      end
      MOVE_DOWN: begin
        if (arrive) begin
          travel_n = '0;
          floor_n  = scan_floor;
          if (f_buttons[scan_floor] || d_buttons[scan_floor] || !any_below) begin
            state_n  = SERVE;
            door_n   = '0;
            clr_here = 1'b1;
            clr_opp  = !any_below;
          end
        end else begin
          travel_n = travel_cnt + 1'b1;
        end
      end
      SERVE: begin
        // Same-direction requests at this floor are absorbed for the whole stop.
        clr_here = 1'b1;
        if (new_here || hold_act) begin
          door_n = '0;
        end else if (door_cnt == DW'(DOOR_CYCLES - 1)) begin
          door_n   = '0;
          travel_n = '0;
          if (dir_up && any_above)       state_n = MOVE_UP;
          else if (!dir_up && any_below) state_n = MOVE_DOWN;
          else if (any_above) begin
            state_n = MOVE_UP;
            dir_n   = 1'b1;
          end else if (any_below) begin
            state_n = MOVE_DOWN;
            dir_n   = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          door_n = door_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sel   = N_FLOORS'(1) << scan_floor;
  assign clr_f = clr_here ? sel : '0;
  assign clr_u = ((clr_here && dir_up) || (clr_opp && !dir_up)) ? sel : '0;
  assign clr_d = ((clr_here && !dir_up) || (clr_opp && dir_up)) ? sel : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_floor  <= '0;
      dir_up     <= 1'b1;
      travel_cnt <= '0;
      door_cnt   <= '0;
      u_buttons  <= '0;
      d_buttons  <= '0;
      f_buttons  <= '0;
    end else begin
      state      <= state_n;
      cur_floor  <= floor_n;
      dir_up     <= dir_n;
      travel_cnt <= travel_n;
      door_cnt   <= door_n;
      u_buttons  <= (u_buttons | up_in) & ~clr_u;
      d_buttons  <= (d_buttons | dn_in) & ~clr_d;
      f_buttons  <= (f_buttons | ext_floor) & ~clr_f;
    end
  end

  assign cur_cmd    = state;
  assign doors_open = (state == SERVE);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: each expected stop (floor, door-open length) is queued
// when its request is driven and checked by a monitor when the doors close.
module tb_elevator_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] ext_up, ext_down, ext_floor;
  logic       door_hold;
  logic [2:0] cur_floor;
  logic [1:0] cur_cmd;
  logic       doors_open;
  logic [7:0] u_buttons, d_buttons, f_buttons;
  logic       dir_up;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  int   open_len = 0;
  logic [2:0] open_floor = '0;
  bit   run_mon = 0;

  elevator_scan_ctrl #(.N_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_up     (ext_up),
    .ext_down   (ext_down),
    .ext_floor  (ext_floor),
    .door_hold  (door_hold),
    .cur_floor  (cur_floor),
    .cur_cmd    (cur_cmd),
    .doors_open (doors_open),
    .u_buttons  (u_buttons),
    .d_buttons  (d_buttons),
    .f_buttons  (f_buttons),
    .dir_up     (dir_up)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] up, input logic [7:0] dn, input logic [7:0] fl);
    ext_up = up; ext_down = dn; ext_floor = fl;
    @(negedge clk);
    ext_up = '0; ext_down = '0; ext_floor = '0;
  endtask

  task automatic wait_cmd(input logic [1:0] cmd, input int budget, input string tag);
    int k = 0;
    while (cur_cmd !== cmd && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, cur_cmd, cmd);
  endtask

  task automatic wait_floor(input logic [2:0] fl, input int budget, input string tag);
    int k = 0;
    while (cur_floor !== fl && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, cur_floor, fl);
  endtask

  task automatic wait_open(input int budget, input string tag);
    int k = 0;
    while (doors_open !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, doors_open, 1'b1);
  endtask

  // scoreboard monitor: one entry {open_len, floor} per completed stop
  always @(negedge clk) begin
    if (rst || !run_mon) begin
      open_len = 0;
    end else begin
      check("doors_vs_cmd", doors_open, (cur_cmd == 2'b11));
      if (doors_open === 1'b1) begin
        open_len++;
        open_floor = cur_floor;
      end else if (open_len > 0) begin
        check("stop_expected", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("stop_floor", open_floor, e[2:0]);
          check("stop_len", open_len, e[15:8]);
        end
        open_len = 0;
      end
    end
  end

  initial begin
    int n_up;
    bit moved;
    rst = 1'b1; ext_up = '0; ext_down = '0; ext_floor = '0; door_hold = 1'b0;
    do_reset(3);
    run_mon = 1;

    // reset state
    check("rst_floor", cur_floor, 3'd0);
    check("rst_cmd", cur_cmd, 2'b00);
    check("rst_doors", doors_open, 1'b0);
    check("rst_dir", dir_up, 1'b1);
    check("rst_latches", {u_buttons, d_buttons, f_buttons}, 24'h0);

    // single car call to floor 3
    exp_q.push_back({8'd6, 8'd3});
    pulse(8'h00, 8'h00, 8'h08);
    check("t1_latch", f_buttons, 8'h08);
    check("t1_still_idle", cur_cmd, 2'b00);
    @(negedge clk);
    n_up = 0;
    while (cur_cmd === 2'b01 && n_up < 100) begin
      n_up++;
      @(negedge clk);
    end
    check("t1_up_cycles", n_up, 12);
    check("t1_floor", cur_floor, 3'd3);
    check("t1_serve", cur_cmd, 2'b11);
    check("t1_fclr", f_buttons, 8'h00);
    wait_cmd(2'b00, 20, "t1_idle");
    check("t1_floor_end", cur_floor, 3'd3);
    tick($urandom_range(1, 3));

    // SCAN ordering: 0->5 with hall up at 4 and hall down at 2 picked up on the way
    do_reset(1);
    exp_q.push_back({8'd6, 8'd4});
    exp_q.push_back({8'd6, 8'd5});
    exp_q.push_back({8'd6, 8'd2});
    pulse(8'h00, 8'h00, 8'h20);
    wait_floor(3'd1, 20, "t2_at1");
    pulse(8'h10, 8'h04, 8'h00);
    check("t2_hall_latch", {u_buttons, d_buttons}, 16'h1004);
    wait_cmd(2'b11, 40, "t2_serve4");
    check("t2_floor4", cur_floor, 3'd4);
    wait_cmd(2'b10, 40, "t2_down");
    check("t2_dir_down", dir_up, 1'b0);
    wait_cmd(2'b00, 60, "t2_idle");
    check("t2_floor_end", cur_floor, 3'd2);
    check("t2_latches", {u_buttons, d_buttons, f_buttons}, 24'h0);
    tick($urandom_range(1, 3));

    // hall call at the current floor: serve without moving
    exp_q.push_back({8'd6, 8'd2});
    pulse(8'h04, 8'h00, 8'h00);
    moved = 0;
    for (int k = 0; k < 30 && cur_cmd !== 2'b00 || k == 0; k++) begin
      @(negedge clk);
      if (cur_cmd === 2'b01 || cur_cmd === 2'b10) moved = 1;
    end
    check("t3_no_move", moved, 1'b0);
    check("t3_floor", cur_floor, 3'd2);
    check("t3_uclr", u_buttons, 8'h00);

    // repeat car call mid-stop reloads the door timer: 3 + 6 open cycles
    exp_q.push_back({8'd9, 8'd2});
    pulse(8'h00, 8'h00, 8'h04);
    wait_open(5, "t4_open");
    tick(2);
    pulse(8'h00, 8'h00, 8'h04);
    check("t4_reload_clr", f_buttons, 8'h00);
    wait_cmd(2'b00, 30, "t4_idle");

    // unreachable hall directions are ignored
    pulse(8'h80, 8'h01, 8'h00);
    check("t5_latches", {u_buttons, d_buttons}, 16'h0000);
    tick(3);
    check("t5_idle", cur_cmd, 2'b00);

    // door hold during a stop at floor 3
`ifdef ELEVATOR_DOOR_HOLD_EN
    exp_q.push_back({8'd16, 8'd3});
`else
    exp_q.push_back({8'd6, 8'd3});
`endif
    pulse(8'h00, 8'h00, 8'h08);
    wait_open(20, "t6_open");
    door_hold = 1'b1;
    tick(10);
    door_hold = 1'b0;
    wait_cmd(2'b00, 30, "t6_idle");
    tick(1);

    // reset mid-travel between floors 2 and 3, with a request presented in the reset cycle
    do_reset(1);
    pulse(8'h00, 8'h00, 8'h40);
    wait_floor(3'd2, 30, "t7_at2");
    tick(1);
    check("t7_moving", cur_cmd, 2'b01);
    rst = 1'b1; ext_up = 8'h20;
    @(negedge clk);
    rst = 1'b0; ext_up = 8'h00;
    check("t7_floor", cur_floor, 3'd0);
    check("t7_cmd", cur_cmd, 2'b00);
    check("t7_doors", doors_open, 1'b0);
    check("t7_latches", {u_buttons, d_buttons, f_buttons}, 24'h0);
    tick(3);
    check("t7_stay_idle", cur_cmd, 2'b00);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
